reg_file_param: RTL and testbench

Parametrised multi-register file: the next generation of the team's 4×32 two-read/one-write register file. Storage width and depth are generic. It adds per-byte write strobes and per-register "written since clear" valid flags, and has an optional write-to-read bypass. It sits in the datapath between the writeback stage and the operand-fetch stage.

---
 rtl/reg_file_param.sv | 82 ++++++++
 tb/tb_reg_file_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: two async read ports, one byte-strobed write port, per-register valid flags.
// Optional write-to-read bypass enabled by defining RF_BYPASS_EN.
module reg_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                wena,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   r0addr,
  input  logic [ADDR_W-1:0]   r1addr,
  output logic [DATA_W-1:0]   r0data,
  output logic [DATA_W-1:0]   r1data,
  output logic                r0valid,
  output logic                r1valid
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_vld;

  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_merged;
  logic              w_any_strb;

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      w_mask[8*i +: 8] = {8{wstrb[i]}};
    end
  end

  assign w_any_strb = |wstrb;
  assign w_merged   = (r_mem[waddr] & ~w_mask) | (wdata & w_mask);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_mem <= '{default: '0};
      r_vld <= '0;
    end else if (!wena) begin
      r_mem[waddr] <= w_merged;
      if (w_any_strb) r_vld[waddr] <= 1'b1;
    end
  end

`ifdef RF_BYPASS_EN
  logic w_byp_act;
  assign w_byp_act = !wena && !clr;

  // Pending write is forwarded so a read in the write cycle sees the merged word.
  always_comb begin
    r0data  = r_mem[r0addr];
    r0valid = r_vld[r0addr];
    if (w_byp_act && (r0addr == waddr)) begin
      r0data  = w_merged;
      r0valid = r_vld[waddr] | w_any_strb;
    end
  end

  always_comb begin
    r1data  = r_mem[r1addr];
    r1valid = r_vld[r1addr];
    if (w_byp_act && (r1addr == waddr)) begin
      r1data  = w_merged;
      r1valid = r_vld[waddr] | w_any_strb;
    end
  end
`else
  always_comb begin
    r0data  = r_mem[r0addr];
    r0valid = r_vld[r0addr];
    r1data  = r_mem[r1addr];
    r1valid = r_vld[r1addr];
  end
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: expected read results queued with stimulus, popped at sampling.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        clr, wena;
  logic [1:0]  waddr, r0addr, r1addr;
  logic [31:0] wdata, r0data, r1data;
  logic [3:0]  wstrb;
  logic        r0valid, r1valid;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    string       name;
    bit          port;
    logic [31:0] d;
    logic        v;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(32), .ADDR_W(2)) dut (
    .clk(clk), .clr(clr), .wena(wena), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .r0addr(r0addr), .r1addr(r1addr), .r0data(r0data), .r1data(r1data),
    .r0valid(r0valid), .r1valid(r1valid)
  );

  task automatic drain();
    exp_t        e;
    logic [31:0] ad;
    logic        av;
    #1;
    while (q.size() > 0) begin
      e  = q.pop_front();
      ad = e.port ? r1data : r0data;
      av = e.port ? r1valid : r0valid;
      vectors++;
      if (ad !== e.d || av !== e.v) begin
        errors++;
        $display("FAIL %s r%0d: got data=%h valid=%b, expected data=%h valid=%b",
                 e.name, e.port, ad, av, e.d, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    wena = 1'b0; waddr = a; wdata = d; wstrb = s;
    tick();
    wena = 1'b1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    do_clear();
    for (int a = 0; a < 4; a++) begin
      r0addr = 2'(a); r1addr = 2'(3 - a);
      q.push_back('{"reset", 1'b0, 32'h0, 1'b0});
      q.push_back('{"reset", 1'b1, 32'h0, 1'b0});
      drain();
    end
  endtask

  task automatic test_full_writes();
    logic [31:0] vals [4] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    for (int a = 0; a < 4; a++) do_write(2'(a), vals[a], 4'hF);
    for (int p = 0; p < 4; p += 2) begin
      r0addr = 2'(p); r1addr = 2'(p + 1);
      q.push_back('{"full_write", 1'b0, vals[p], 1'b1});
      q.push_back('{"full_write", 1'b1, vals[p+1], 1'b1});
      drain();
    end
  endtask

  task automatic test_byte_strobes();
    do_write(2'd2, 32'hCCCCCCCC, 4'hF);
    do_write(2'd2, 32'h11223344, 4'b0101);
    r0addr = 2'd2; r1addr = 2'd2;
    q.push_back('{"strobe_0101", 1'b0, 32'hCC22CC44, 1'b1});
    q.push_back('{"strobe_0101", 1'b1, 32'hCC22CC44, 1'b1});
    drain();
    do_write(2'd2, 32'h55667788, 4'b0000);
    q.push_back('{"strobe_none", 1'b0, 32'hCC22CC44, 1'b1});
    drain();
    do_write(2'd1, 32'h0000AB00, 4'b0010);
    r1addr = 2'd1;
    q.push_back('{"strobe_lane1", 1'b1, 32'hBBBBABBB, 1'b1});
    drain();
    do_clear();
    do_write(2'd3, 32'hFFFFFFFF, 4'b0000);
    r0addr = 2'd3;
    q.push_back('{"strobe_none_vld", 1'b0, 32'h0, 1'b0});
    drain();
  endtask

  task automatic test_write_disabled();
    do_clear();
    wena = 1'b1; waddr = 2'd0; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    r0addr = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      q.push_back('{"write_disabled", 1'b0, 32'h0, 1'b0});
      drain();
    end
  endtask

  task automatic test_clear_collision();
    do_write(2'd1, 32'hFEEDFACE, 4'hF);
    clr = 1'b1; wena = 1'b0; waddr = 2'd1; wdata = 32'h12345678; wstrb = 4'hF;
    r0addr = 2'd1; r1addr = 2'd1;
    tick();
    q.push_back('{"clr_collision", 1'b1, 32'h0, 1'b0});
    drain();
    clr = 1'b0;
    tick();
    wena = 1'b1;
    q.push_back('{"post_collision", 1'b1, 32'h12345678, 1'b1});
    drain();
    r0addr = 2'd0;
    q.push_back('{"post_collision_r0", 1'b0, 32'h0, 1'b0});
    drain();
  endtask

  task automatic test_same_cycle();
    do_write(2'd3, 32'hDDDDDDDD, 4'hF);
    wena = 1'b0; waddr = 2'd3; wdata = 32'h0000FFFF; wstrb = 4'b0011;
    r0addr = 2'd3; r1addr = 2'd2;
`ifdef RF_BYPASS_EN
    q.push_back('{"same_cycle_pre", 1'b0, 32'hDDDDFFFF, 1'b1});
`else
    q.push_back('{"same_cycle_pre", 1'b0, 32'hDDDDDDDD, 1'b1});
`endif
    q.push_back('{"same_cycle_other", 1'b1, 32'h0, 1'b0});
    drain();
    tick();
    wena = 1'b1;
    q.push_back('{"same_cycle_post", 1'b0, 32'hDDDDFFFF, 1'b1});
    drain();
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int a = 0; a < 4; a++) do_write(2'(a), 32'h01010101 * (a + 1), 4'hF);
    do_write(2'd0, 32'hA5A5A5A5, 4'b1000);
    r0addr = 2'd0; r1addr = 2'd3;
    q.push_back('{"b2b_r0", 1'b0, 32'hA5010101, 1'b1});
    q.push_back('{"b2b_r3", 1'b1, 32'h04040404, 1'b1});
    drain();
  endtask

  initial begin
    clr = 1'b0; wena = 1'b1; waddr = '0; wdata = '0; wstrb = '0;
    r0addr = '0; r1addr = '0;
    tick();
    test_reset();
    test_full_writes();
    test_byte_strobes();
    test_write_disabled();
    test_clear_collision();
    test_same_cycle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
